// File: rtl/mmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mmem_responder
// Purpose  : Byte-serial main-memory responder with RAM plus an I/O window
//            (TX/RX byte FIFOs, status byte, halt flag). Optional RX FIFO
//            is built when MMEM_RX_FIFO_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module mmem_responder #(
    parameter int ADDR_WIDTH = 17,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mmem_r_w,
    input  logic [31:0] mmem_addr,
    input  logic [7:0]  mmem_data,
    output logic [7:0]  data_get,
    output logic [7:0]  tx_data,
    output logic        tx_valid,
    input  logic        tx_ready,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        rx_ready,
    output logic        halt
);

    localparam int                  c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int                  c_CNT_W   = c_PTR_W + 1;
    localparam logic [c_CNT_W-1:0]  c_FULL    = c_CNT_W'(FIFO_DEPTH);
    localparam logic [c_CNT_W-1:0]  c_ONE     = c_CNT_W'(1);
    localparam logic [c_PTR_W-1:0]  c_PTR_ONE = c_PTR_W'(1);
    localparam logic [15:0]         c_IO_DATA = 16'h0000;
    localparam logic [15:0]         c_IO_STAT = 16'h0004;

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic                  io_sel;
    logic                  is_data;
    logic                  is_stat;
    logic                  rd_data_acc;
    logic                  wr_data_acc;
    logic                  wr_stat_acc;
    logic [ADDR_WIDTH-1:0] ram_addr;

    assign io_sel      = (mmem_addr[17:16] == 2'b11);
    assign is_data     = io_sel && (mmem_addr[15:0] == c_IO_DATA);
    assign is_stat     = io_sel && (mmem_addr[15:0] == c_IO_STAT);
    assign rd_data_acc = is_data && !mmem_r_w;
    assign wr_data_acc = is_data &&  mmem_r_w;
    assign wr_stat_acc = is_stat &&  mmem_r_w;
    assign ram_addr    = mmem_addr[ADDR_WIDTH-1:0];

    // ------------------------------------------------------------------
    // RAM (contents survive reset)
    // ------------------------------------------------------------------
    logic [7:0] ram [0:(1<<ADDR_WIDTH)-1];

    always_ff @(posedge clk) begin
        if (mmem_r_w && !io_sel) begin
            ram[ram_addr] <= mmem_data;
        end
    end

    // ------------------------------------------------------------------
    // TX FIFO
    // ------------------------------------------------------------------
    logic [7:0]         tx_buf [0:FIFO_DEPTH-1];
    logic [c_CNT_W-1:0] tx_cnt_q,    tx_cnt_d;
    logic [c_PTR_W-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [c_PTR_W-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic               tx_ovf_q,    tx_ovf_d;
    logic               tx_full;
    logic               tx_nonempty;
    logic               tx_pop;
    logic               tx_push;

    assign tx_full     = (tx_cnt_q == c_FULL);
    assign tx_nonempty = (tx_cnt_q != '0);
    assign tx_pop      = tx_nonempty && tx_ready;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign tx_push     = wr_data_acc && (!tx_full || tx_pop);

    always_comb begin
        tx_cnt_d    = tx_cnt_q;
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_ovf_d    = tx_ovf_q | (wr_data_acc && !tx_push);
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + c_PTR_ONE;
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + c_PTR_ONE;
        case ({tx_push, tx_pop})
            2'b10:   tx_cnt_d = tx_cnt_q + c_ONE;
            2'b01:   tx_cnt_d = tx_cnt_q - c_ONE;
            default: tx_cnt_d = tx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_buf[tx_wr_ptr_q] <= mmem_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tx_cnt_q    <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_ovf_q    <= 1'b0;
        end else begin
            tx_cnt_q    <= tx_cnt_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_ovf_q    <= tx_ovf_d;
        end
    end

    assign tx_valid = tx_nonempty;
    assign tx_data  = tx_nonempty ? tx_buf[tx_rd_ptr_q] : 8'h00;

    // ------------------------------------------------------------------
    // RX FIFO (optional)
    // ------------------------------------------------------------------
    logic       rx_nonempty;
    logic [7:0] rx_head;
    logic       rx_pop;
    logic       prev_rd_q, prev_rd_d;

`ifdef MMEM_RX_FIFO_EN
    logic [7:0]         rx_buf [0:FIFO_DEPTH-1];
    logic [c_CNT_W-1:0] rx_cnt_q,    rx_cnt_d;
    logic [c_PTR_W-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [c_PTR_W-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic               rx_full;
    logic               rx_push;

    assign rx_full     = (rx_cnt_q == c_FULL);
    assign rx_nonempty = (rx_cnt_q != '0);
    assign rx_push     = rx_valid && !rx_full;
    // An idle controller holding the data address must not drain the FIFO.
    assign rx_pop      = rd_data_acc && !prev_rd_q && rx_nonempty;
    assign rx_head     = rx_buf[rx_rd_ptr_q];
    assign rx_ready    = !rx_full;

    always_comb begin
        rx_cnt_d    = rx_cnt_q;
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + c_PTR_ONE;
        if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + c_PTR_ONE;
        case ({rx_push, rx_pop})
            2'b10:   rx_cnt_d = rx_cnt_q + c_ONE;
            2'b01:   rx_cnt_d = rx_cnt_q - c_ONE;
            default: rx_cnt_d = rx_cnt_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_buf[rx_wr_ptr_q] <= rx_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_cnt_q    <= '0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
        end else begin
            rx_cnt_q    <= rx_cnt_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
        end
    end
`else
    logic unused_rx;
    assign unused_rx   = ^{rx_data, rx_valid};
    assign rx_nonempty = 1'b0;
    assign rx_head     = 8'h00;
    assign rx_pop      = 1'b0;
    assign rx_ready    = 1'b0;
`endif

    // ------------------------------------------------------------------
    // Read data, halt and repeated-read tracking
    // ------------------------------------------------------------------
    logic [7:0] data_get_q, data_get_d;
    logic       halt_q,     halt_d;

    assign prev_rd_d = rd_data_acc;
    assign halt_d    = halt_q | wr_stat_acc;

    always_comb begin
        data_get_d = data_get_q;
        if (!mmem_r_w) begin
            if (!io_sel) begin
                data_get_d = ram[ram_addr];
            end else if (is_data) begin
                // A held repeat of the data read keeps the byte it already returned.
                if (rx_pop)          data_get_d = rx_head;
                else if (!prev_rd_q) data_get_d = 8'h00;
            end else if (is_stat) begin
                data_get_d = {5'b0, tx_ovf_q, tx_full, rx_nonempty};
            end else begin
                data_get_d = 8'h00;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_get_q <= 8'h00;
            halt_q     <= 1'b0;
            prev_rd_q  <= 1'b0;
        end else begin
            data_get_q <= data_get_d;
            halt_q     <= halt_d;
            prev_rd_q  <= prev_rd_d;
        end
    end

    assign data_get = data_get_q;
    assign halt     = halt_q;

    logic unused_addr;
    assign unused_addr = ^mmem_addr[31:18];

endmodule
`default_nettype wire

// File: tb/tb_mmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mmem_responder
// Purpose  : Directed self-checking bench for mmem_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mmem_responder;

    logic        clk;
    logic        rst;
    logic        mmem_r_w;
    logic [31:0] mmem_addr;
    logic [7:0]  mmem_data;
    logic [7:0]  data_get;
    logic [7:0]  tx_data;
    logic        tx_valid;
    logic        tx_ready;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        halt;

    int n_total = 0;
    int n_bad   = 0;

    localparam logic [31:0] c_IDLE = 32'h0000_0100;

`ifdef MMEM_RX_FIFO_EN
    localparam logic c_RX_RDY_RST = 1'b1;
`else
    localparam logic c_RX_RDY_RST = 1'b0;
`endif

    mmem_responder #(
        .ADDR_WIDTH (17),
        .FIFO_DEPTH (16)
    ) u_dut (
        .clk       (clk),
        .rst       (rst),
        .mmem_r_w  (mmem_r_w),
        .mmem_addr (mmem_addr),
        .mmem_data (mmem_data),
        .data_get  (data_get),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .rx_data   (rx_data),
        .rx_valid  (rx_valid),
        .rx_ready  (rx_ready),
        .halt      (halt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus(input logic rw, input logic [31:0] addr, input logic [7:0] data);
        mmem_r_w  = rw;
        mmem_addr = addr;
        mmem_data = data;
        tick();
        mmem_r_w  = 1'b0;
        mmem_addr = c_IDLE;
        mmem_data = 8'h00;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] pre [0:3];
        pre[0] = 8'h11; pre[1] = 8'h22; pre[2] = 8'h33; pre[3] = 8'h44;

        rst       = 1'b1;
        mmem_r_w  = 1'b0;
        mmem_addr = c_IDLE;
        mmem_data = 8'h00;
        tx_ready  = 1'b0;
        rx_data   = 8'h00;
        rx_valid  = 1'b0;
        tick();
        tick();
        chk("rst_data_get", {24'd0, data_get}, 32'h00);
        chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("rst_tx_data",  {24'd0, tx_data},  32'h00);
        chk("rst_rx_ready", {31'd0, rx_ready}, {31'd0, c_RX_RDY_RST});
        chk("rst_halt",     {31'd0, halt},     32'd0);
        rst = 1'b0;
        tick();

        // RAM write then read-back, and persistence across reset
        bus(1'b1, 32'h0001_0, 8'hA5);
        bus(1'b0, 32'h0000_0010, 8'h00);
        chk("ram_rd_after_wr", {24'd0, data_get}, 32'hA5);
        do_reset();
        bus(1'b0, 32'h0000_0010, 8'h00);
        chk("ram_kept_by_rst", {24'd0, data_get}, 32'hA5);

        // Back-to-back incrementing reads
        for (int i = 0; i < 4; i++) bus(1'b1, 32'(i), pre[i]);
        for (int i = 0; i < 4; i++) begin
            bus(1'b0, 32'(i), 8'h00);
            chk($sformatf("ram_seq%0d", i), {24'd0, data_get}, {24'd0, pre[i]});
        end

        // Unmapped I/O address
        bus(1'b1, 32'h0003_0008, 8'h5A);
        bus(1'b0, 32'h0003_0008, 8'h00);
        chk("io_other_rd", {24'd0, data_get}, 32'h00);

        // TX overflow: 17 writes into a 16-deep FIFO
        tx_ready = 1'b0;
        for (int i = 0; i < 17; i++) begin
            bus(1'b1, 32'h0003_0000, 8'(i));
            if (i == 0) begin
                chk("tx_valid_first", {31'd0, tx_valid}, 32'd1);
                chk("tx_data_first",  {24'd0, tx_data},  32'h00);
            end
        end
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("stat_ovf_full", {24'd0, data_get}, 32'h06);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_drain%0d", i), {24'd0, tx_data}, 32'(i));
            tick();
        end
        chk("tx_empty_after", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;
        do_reset();

        // Full FIFO with simultaneous push and pop
        for (int i = 0; i < 16; i++) bus(1'b1, 32'h0003_0000, 8'(8'h80 + i));
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("stat_full", {24'd0, data_get}, 32'h02);
        tx_ready = 1'b1;
        bus(1'b1, 32'h0003_0000, 8'hC0);
        tx_ready = 1'b0;
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("stat_full_pushpop", {24'd0, data_get}, 32'h02);
        tx_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk($sformatf("tx_pp%0d", i), {24'd0, tx_data},
                (i < 15) ? 32'(8'h81 + i) : 32'hC0);
            tick();
        end
        chk("tx_pp_empty", {31'd0, tx_valid}, 32'd0);
        tx_ready = 1'b0;

`ifdef MMEM_RX_FIFO_EN
        // RX path and repeated-read qualifier
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        tick();
        rx_data  = 8'h42;
        tick();
        rx_valid = 1'b0;
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("stat_rx", {24'd0, data_get}, 32'h01);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_first", {24'd0, data_get}, 32'h41);
        bus(1'b0, 32'h0003_0000, 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        bus(1'b0, 32'h0000_0100, 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_second", {24'd0, data_get}, 32'h42);
        bus(1'b0, 32'h0000_0200, 8'h00);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_empty_rd", {24'd0, data_get}, 32'h00);

        // RX fill to full
        rx_valid = 1'b1;
        for (int i = 0; i < 16; i++) begin
            rx_data = 8'(8'h60 + i);
            tick();
            if (i == 14) chk("rx_ready_15", {31'd0, rx_ready}, 32'd1);
        end
        rx_valid = 1'b0;
        chk("rx_ready_full", {31'd0, rx_ready}, 32'd0);
        bus(1'b0, 32'h0003_0000, 8'h00);
        chk("rx_full_head", {24'd0, data_get}, 32'h60);
        chk("rx_ready_pop", {31'd0, rx_ready}, 32'd1);
`else
        rx_valid = 1'b1;
        rx_data  = 8'h41;
        tick();
        bus(1'b0, 32'h0003_0000, 8'h00);
        rx_valid = 1'b0;
        chk("norx_rd", {24'd0, data_get}, 32'h00);
        chk("norx_ready", {31'd0, rx_ready}, 32'd0);
        bus(1'b0, 32'h0003_0004, 8'h00);
        chk("norx_stat", {24'd0, data_get}, 32'h00);
`endif

        // Halt, then asynchronous reset mid-burst
        chk("halt_before", {31'd0, halt}, 32'd0);
        bus(1'b1, 32'h0003_0004, 8'h00);
        chk("halt_set", {31'd0, halt}, 32'd1);
        bus(1'b1, 32'h0003_0000, 8'h55);
        bus(1'b1, 32'h0003_0000, 8'h56);
        bus(1'b0, 32'h0000_0010, 8'h00);
        chk("pre_rst_data", {24'd0, data_get}, 32'hA5);
        #2;
        rst = 1'b1;
        #1;
        chk("arst_halt",     {31'd0, halt},     32'd0);
        chk("arst_tx_valid", {31'd0, tx_valid}, 32'd0);
        chk("arst_rx_ready", {31'd0, rx_ready}, {31'd0, c_RX_RDY_RST});
        chk("arst_data_get", {24'd0, data_get}, 32'h00);
        tick();
        rst = 1'b0;
        bus(1'b0, 32'h0000_0003, 8'h00);
        chk("ram_kept_arst", {24'd0, data_get}, 32'h44);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
